// File: rtl/store_rmw_if.sv
// Store request / word-RAM bus between the MEM-stage pipeline, the store
// read-modify-write unit and the data RAM.
interface store_rmw_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_type;

  logic [ADDR_W-3:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rd_data;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_data;
  logic [3:0]        mem_be;

  logic              misalign_exc;
  logic [ADDR_W-1:0] exc_addr;

  // Pipeline + RAM side: issues requests and returns read data.
  modport master (
    output req_valid, req_addr, req_data, req_type, mem_rd_data,
    input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, mem_be,
           misalign_exc, exc_addr
  );

  // Store unit side.
  modport slave (
    input  req_valid, req_addr, req_data, req_type, mem_rd_data,
    output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, mem_be,
           misalign_exc, exc_addr
  );
endinterface

// File: rtl/store_rmw_unit.sv
// MEM-stage store unit: sw writes the word RAM directly, sb/sh do a
// read-modify-write of the containing word. Alignment faults raise a pulse.
module store_rmw_unit #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  store_rmw_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, MERGE, WR} state_t;
  typedef enum logic [1:0] {ST_SW = 2'b00, ST_SH = 2'b01, ST_SB = 2'b10, ST_RSV = 2'b11} st_type_t;

  state_t     state;
  st_type_t   cap_type;
  logic [1:0] cap_lane;
  logic [15:0] cap_data;

  st_type_t   in_type;
  logic       misaligned;
  logic       is_word;
  logic [31:0] merged;
  logic [3:0]  merged_be;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    in_type    = st_type_t'(bus.req_type);
    misaligned = 1'b0;
    is_word    = 1'b0;
    case (in_type)
      ST_SB:   misaligned = 1'b0;
      ST_SH:   misaligned = bus.req_addr[0];
      default: begin
        misaligned = |bus.req_addr[1:0];
        is_word    = 1'b1;
      end
    endcase
  end

  // Lanes not targeted by the store pass the read word through untouched.
  always_comb begin
    merged    = bus.mem_rd_data;
    merged_be = 4'b0000;
    if (cap_type == ST_SB) begin
      merged[{cap_lane, 3'b000} +: 8] = cap_data[7:0];
      merged_be = 4'b0001 << cap_lane;
    end else if (cap_lane[1]) begin
      merged[31:16] = cap_data;
      merged_be     = 4'b1100;
    end else begin
      merged[15:0] = cap_data;
      merged_be    = 4'b0011;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cap_type         <= ST_SW;
      cap_lane         <= '0;
      cap_data         <= '0;
      bus.req_ready    <= 1'b1;
      bus.mem_rd_en    <= 1'b0;
      bus.mem_wr_en    <= 1'b0;
      bus.misalign_exc <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wr_data  <= '0;
      bus.mem_be       <= '0;
      bus.exc_addr     <= '0;
    end else begin
      bus.misalign_exc <= 1'b0;
      bus.mem_rd_en    <= 1'b0;
      bus.mem_wr_en    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (misaligned) begin
              bus.misalign_exc <= 1'b1;
              bus.exc_addr     <= bus.req_addr;
            end else begin
              cap_type      <= in_type;
              cap_lane      <= bus.req_addr[1:0];
              cap_data      <= bus.req_data[15:0];
              bus.mem_addr  <= bus.req_addr[ADDR_W-1:2];
              bus.req_ready <= 1'b0;
              if (is_word) begin
                state           <= WR;
                bus.mem_wr_en   <= 1'b1;
                bus.mem_wr_data <= bus.req_data;
                bus.mem_be      <= 4'b1111;
              end else begin
                state         <= RD;
                bus.mem_rd_en <= 1'b1;
              end
            end
          end
        end
        RD:    state <= (RD_LAT == 2) ? WAIT : MERGE;
        WAIT:  state <= MERGE;
        MERGE: begin
          // The merged word is built straight into the write-data register.
          state           <= WR;
          bus.mem_wr_en   <= 1'b1;
          bus.mem_wr_data <= merged;
          bus.mem_be      <= merged_be;
        end
        WR: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
